// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle between the UART decoder, the word assembler and the display path.
// The slave modport is the assembler; the master modport is the decoder/consumer side.
interface uart_word_assembler_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferror;
    logic                 rx_perror;
    logic [15:0]          word;
    logic                 word_valid;
    logic                 word_error;
    logic                 word_timeout;
    logic                 busy;
    logic [ERR_CNT_W-1:0] err_count;
    logic [15:0]          display_data;

    modport slave (
        input  en, rx_data, rx_valid, rx_ferror, rx_perror,
        output word, word_valid, word_error, word_timeout, busy, err_count, display_data
    );

    modport master (
        output en, rx_data, rx_valid, rx_ferror, rx_perror,
        input  word, word_valid, word_error, word_timeout, busy, err_count, display_data
    );
endinterface

// File: rtl/uart_word_assembler.sv
// Reassembles MS then LS received bytes into a 16-bit word, counts aborted words, drives 7-seg data.
// Define WORD_TIMEOUT_EN to abort a word whose LS byte fails to arrive within TIMEOUT_CYCLES.
module uart_word_assembler #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter int          ERR_CNT_W      = 8,
    parameter logic [15:0] ERR_GLYPH      = 16'hBBBB
) (
    input  logic clk,
    input  logic reset,
    uart_word_assembler_if.slave bus
);
    typedef enum logic {S_MS = 1'b0, S_LS = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [7:0]           ms_q, ms_d;
    logic [15:0]          word_q, word_d;
    logic                 word_valid_q, word_valid_d;
    logic                 word_error_q, word_error_d;
    logic                 word_timeout_q, word_timeout_d;
    logic                 err_latched_q, err_latched_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 byte_ok, byte_bad, abort;

`ifdef WORD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign byte_ok  = bus.rx_valid & ~bus.rx_ferror & ~bus.rx_perror;
    assign byte_bad = bus.rx_valid & (bus.rx_ferror | bus.rx_perror);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_MS;
            ms_q           <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            word_error_q   <= 1'b0;
            word_timeout_q <= 1'b0;
            err_latched_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            ms_q           <= ms_d;
            word_q         <= word_d;
            word_valid_q   <= word_valid_d;
            word_error_q   <= word_error_d;
            word_timeout_q <= word_timeout_d;
            err_latched_q  <= err_latched_d;
            err_count_q    <= err_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ms_d           = ms_q;
        word_d         = word_q;
        word_valid_d   = 1'b0;
        word_error_d   = 1'b0;
        word_timeout_d = 1'b0;
        err_latched_d  = err_latched_q;
        err_count_d    = err_count_q;
        abort          = 1'b0;
`ifdef WORD_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        // Disabling drops any half-assembled word silently; no error is recorded.
        if (!bus.en) begin
            state_d = S_MS;
        end else begin
            case (state_q)
                S_MS: begin
                    if (byte_ok) begin
                        ms_d    = bus.rx_data;
                        state_d = S_LS;
`ifdef WORD_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else if (byte_bad) begin
                        abort = 1'b1;
                    end
                end
                S_LS: begin
                    if (byte_ok) begin
                        word_d        = {ms_q, bus.rx_data};
                        word_valid_d  = 1'b1;
                        err_latched_d = 1'b0;
                        state_d       = S_MS;
                    end else if (byte_bad) begin
                        abort   = 1'b1;
                        state_d = S_MS;
                    end
`ifdef WORD_TIMEOUT_EN
                    // An arriving byte on the expiry cycle takes priority over the timeout.
                    else if (cnt_q == CNT_LAST) begin
                        abort          = 1'b1;
                        word_timeout_d = 1'b1;
                        state_d        = S_MS;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                default: state_d = S_MS;
            endcase
        end

        if (abort) begin
            word_error_d  = 1'b1;
            err_latched_d = 1'b1;
            if (err_count_q != {ERR_CNT_W{1'b1}})
                err_count_d = err_count_q + 1'b1;
        end
    end

    assign bus.word         = word_q;
    assign bus.word_valid   = word_valid_q;
    assign bus.word_error   = word_error_q;
    assign bus.word_timeout = word_timeout_q;
    assign bus.busy         = (state_q == S_LS);
    assign bus.err_count    = err_count_q;
    assign bus.display_data = err_latched_q ? ERR_GLYPH : word_q;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Randomised and directed bench for uart_word_assembler against a transaction-level word model.
// Build with +define+WORD_TIMEOUT_EN to exercise the LS-byte timeout.
module tb_uart_word_assembler;
    localparam int TO_CYCLES = 20;
    localparam int CW        = 8;
    localparam int CMAX      = (1 << CW) - 1;
`ifdef WORD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_word_assembler_if #(.ERR_CNT_W(CW)) bus ();

    uart_word_assembler #(
        .TIMEOUT_CYCLES(TO_CYCLES),
        .ERR_CNT_W     (CW),
        .ERR_GLYPH     (16'hBBBB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: a word is a pending MS byte plus a completing LS byte; anything else is an abort.
    bit        m_pending;
    bit [7:0]  m_ms;
    bit [15:0] m_word;
    bit        m_latched;
    int        m_errcnt;
    int        m_wait;
    bit        e_valid, e_err, e_to;

    function automatic void model_reset();
        m_pending = 0; m_ms = 0; m_word = 0; m_latched = 0; m_errcnt = 0; m_wait = 0;
        e_valid = 0; e_err = 0; e_to = 0;
    endfunction

    function automatic void model_abort();
        e_err = 1; m_latched = 1; m_pending = 0;
        if (m_errcnt < CMAX) m_errcnt++;
    endfunction

    function automatic void model_cycle(bit en, bit v, bit [7:0] d, bit fe, bit pe);
        e_valid = 0; e_err = 0; e_to = 0;
        if (!en) begin
            m_pending = 0;
        end else if (v && !fe && !pe) begin
            if (m_pending) begin
                m_word = {m_ms, d}; e_valid = 1; m_latched = 0; m_pending = 0;
            end else begin
                m_ms = d; m_pending = 1; m_wait = 0;
            end
        end else if (v) begin
            model_abort();
        end else if (m_pending && TO_EN) begin
            m_wait++;
            if (m_wait == TO_CYCLES) begin
                model_abort(); e_to = 1;
            end
        end
    endfunction

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic step(input bit en, input bit v, input bit [7:0] d, input bit fe, input bit pe);
        bus.en = en; bus.rx_valid = v; bus.rx_data = d; bus.rx_ferror = fe; bus.rx_perror = pe;
        @(posedge clk);
        model_cycle(en, v, d, fe, pe);
        #1;
        bus.rx_valid = 0; bus.rx_ferror = 0; bus.rx_perror = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.word !== 16'h0 || bus.word_valid !== 0 || bus.word_error !== 0 || bus.word_timeout !== 0 ||
            bus.busy !== 0 || bus.err_count !== 8'h00 || bus.display_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: word=%h v=%b e=%b t=%b busy=%b cnt=%h disp=%h want all zero",
                     bus.word, bus.word_valid, bus.word_error, bus.word_timeout, bus.busy,
                     bus.err_count, bus.display_data);
        end
        $display("test_reset: word=%h cnt=%h disp=%h", bus.word, bus.err_count, bus.display_data);
    endtask

    task automatic test_basic_pair();
        step(1, 1, 8'hA5, 0, 0);
        checks++;
        if (bus.busy !== 1 || bus.word_valid !== 0) begin
            errors++;
            $display("FAIL basic_ms: busy=%b valid=%b want busy=1 valid=0", bus.busy, bus.word_valid);
        end
        step(1, 1, 8'h3C, 0, 0);
        checks++;
        if (bus.word !== 16'hA53C || bus.word_valid !== 1 || bus.display_data !== 16'hA53C || bus.busy !== 0) begin
            errors++;
            $display("FAIL basic_word: word=%h valid=%b disp=%h busy=%b want A53C 1 A53C 0",
                     bus.word, bus.word_valid, bus.display_data, bus.busy);
        end
        idle(1);
        checks++;
        if (bus.word_valid !== 0) begin
            errors++;
            $display("FAIL basic_pulse_width: valid=%b want 0", bus.word_valid);
        end
        $display("test_basic_pair: word=%h", bus.word);
    endtask

    task automatic test_ms_error();
        step(1, 1, 8'h12, 0, 1);
        checks++;
        if (bus.word_error !== 1 || bus.err_count !== 8'd1 || bus.display_data !== 16'hBBBB || bus.busy !== 0) begin
            errors++;
            $display("FAIL ms_perror: err=%b cnt=%h disp=%h busy=%b want 1 01 BBBB 0",
                     bus.word_error, bus.err_count, bus.display_data, bus.busy);
        end
        step(1, 1, 8'h12, 0, 0);
        step(1, 1, 8'h34, 0, 0);
        checks++;
        if (bus.word !== 16'h1234 || bus.display_data !== 16'h1234 || bus.word_valid !== 1 || bus.word_error !== 0) begin
            errors++;
            $display("FAIL recover_word: word=%h disp=%h valid=%b err=%b want 1234 1234 1 0",
                     bus.word, bus.display_data, bus.word_valid, bus.word_error);
        end
        $display("test_ms_error: word=%h cnt=%h", bus.word, bus.err_count);
    endtask

    task automatic test_ls_error();
        step(1, 1, 8'h55, 0, 0);
        step(1, 1, 8'h66, 1, 0);
        checks++;
        if (bus.word !== 16'h1234 || bus.word_error !== 1 || bus.word_valid !== 0 || bus.busy !== 0 ||
            bus.err_count !== 8'd2 || bus.display_data !== 16'hBBBB) begin
            errors++;
            $display("FAIL ls_ferror: word=%h err=%b valid=%b busy=%b cnt=%h disp=%h want 1234 1 0 0 02 BBBB",
                     bus.word, bus.word_error, bus.word_valid, bus.busy, bus.err_count, bus.display_data);
        end
        // The next clean byte must be taken as a fresh MS byte.
        step(1, 1, 8'h9A, 0, 0);
        checks++;
        if (bus.busy !== 1 || bus.word_valid !== 0) begin
            errors++;
            $display("FAIL ls_err_then_ms: busy=%b valid=%b want 1 0", bus.busy, bus.word_valid);
        end
        step(1, 1, 8'hBC, 0, 0);
        checks++;
        if (bus.word !== 16'h9ABC || bus.display_data !== 16'h9ABC) begin
            errors++;
            $display("FAIL ls_err_recover: word=%h disp=%h want 9ABC", bus.word, bus.display_data);
        end
        $display("test_ls_error: word=%h cnt=%h", bus.word, bus.err_count);
    endtask

    task automatic test_en_drop();
        step(1, 1, 8'h77, 0, 0);
        step(0, 1, 8'h99, 0, 1);
        checks++;
        if (bus.busy !== 0 || bus.word_valid !== 0 || bus.word_error !== 0 || bus.err_count !== 8'd2) begin
            errors++;
            $display("FAIL en_low: busy=%b valid=%b err=%b cnt=%h want 0 0 0 02",
                     bus.busy, bus.word_valid, bus.word_error, bus.err_count);
        end
        step(1, 1, 8'h88, 0, 0);
        checks++;
        if (bus.word_valid !== 0 || bus.busy !== 1 || bus.word !== 16'h9ABC) begin
            errors++;
            $display("FAIL en_resume_ms: valid=%b busy=%b word=%h want 0 1 9ABC",
                     bus.word_valid, bus.busy, bus.word);
        end
        step(1, 1, 8'h01, 0, 0);
        checks++;
        if (bus.word !== 16'h8801) begin
            errors++;
            $display("FAIL en_resume_word: word=%h want 8801", bus.word);
        end
        $display("test_en_drop: word=%h", bus.word);
    endtask

    task automatic test_timeout();
        int cnt0;
        cnt0 = m_errcnt;
        step(1, 1, 8'hAA, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            step(1, 0, 8'h00, 0, 0);
            checks++;
            if (bus.word_timeout !== e_to || bus.word_error !== e_err || bus.busy !== m_pending) begin
                errors++;
                $display("FAIL timeout_idle%0d: to=%b err=%b busy=%b want %b %b %b",
                         i, bus.word_timeout, bus.word_error, bus.busy, e_to, e_err, m_pending);
            end
            if (TO_EN && i == TO_CYCLES) begin
                checks++;
                if (bus.word_timeout !== 1 || bus.word_error !== 1 || int'(bus.err_count) != cnt0 + 1) begin
                    errors++;
                    $display("FAIL timeout_expiry: to=%b err=%b cnt=%0d want 1 1 %0d",
                             bus.word_timeout, bus.word_error, bus.err_count, cnt0 + 1);
                end
            end
        end
        if (m_pending) step(1, 1, 8'hCD, 0, 0);
        // LS byte landing on the would-be expiry cycle is accepted.
        step(1, 1, 8'hAA, 0, 0);
        idle(TO_CYCLES - 1);
        step(1, 1, 8'h55, 0, 0);
        checks++;
        if (bus.word !== 16'hAA55 || bus.word_valid !== 1 || bus.word_timeout !== 0 || bus.word_error !== 0) begin
            errors++;
            $display("FAIL timeout_race: word=%h valid=%b to=%b err=%b want AA55 1 0 0",
                     bus.word, bus.word_valid, bus.word_timeout, bus.word_error);
        end
        $display("test_timeout: word=%h cnt=%h", bus.word, bus.err_count);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 600; i++) begin
            bit en, v, fe, pe;
            en = ($urandom_range(0, 15) != 0);
            v  = ($urandom_range(0, 3) != 0);
            fe = ($urandom_range(0, 9) == 0);
            pe = ($urandom_range(0, 9) == 0);
            step(en, v, 8'($urandom), fe, pe);
            checks++;
            if (bus.word !== m_word || bus.word_valid !== e_valid || bus.word_error !== e_err ||
                bus.word_timeout !== e_to || bus.busy !== m_pending || int'(bus.err_count) != m_errcnt ||
                bus.display_data !== (m_latched ? 16'hBBBB : m_word)) begin
                errors++;
                $display("FAIL random%0d: word=%h v=%b e=%b t=%b busy=%b cnt=%0d disp=%h want %h %b %b %b %b %0d %h",
                         i, bus.word, bus.word_valid, bus.word_error, bus.word_timeout, bus.busy,
                         bus.err_count, bus.display_data, m_word, e_valid, e_err, e_to, m_pending,
                         m_errcnt, m_latched ? 16'hBBBB : m_word);
            end
        end
        $display("test_back_to_back_random: word=%h cnt=%0d", bus.word, bus.err_count);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 254; i++) step(1, 1, 8'($urandom), 1, 0);
        checks++;
        if (bus.err_count !== 8'hFE) begin
            errors++;
            $display("FAIL sat_fe: cnt=%h want FE", bus.err_count);
        end
        step(1, 1, 8'h00, 0, 1);
        checks++;
        if (bus.err_count !== 8'hFF) begin
            errors++;
            $display("FAIL sat_ff: cnt=%h want FF", bus.err_count);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 1, 1);
        checks++;
        if (bus.err_count !== 8'hFF || bus.word_error !== 1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%h err=%b want FF 1", bus.err_count, bus.word_error);
        end
        $display("test_saturate: cnt=%h", bus.err_count);
    endtask

    task automatic test_reset_mid_ls();
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        checks++;
        if (bus.busy !== 1) begin
            errors++;
            $display("FAIL pre_reset_busy: busy=%b want 1", bus.busy);
        end
        #2 reset = 1;
        #1;
        checks++;
        if (bus.word !== 16'h0 || bus.busy !== 0 || bus.err_count !== 8'h00 || bus.display_data !== 16'h0 ||
            bus.word_valid !== 0 || bus.word_error !== 0 || bus.word_timeout !== 0) begin
            errors++;
            $display("FAIL async_reset: word=%h busy=%b cnt=%h disp=%h v=%b e=%b t=%b want all zero",
                     bus.word, bus.busy, bus.err_count, bus.display_data, bus.word_valid,
                     bus.word_error, bus.word_timeout);
        end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        $display("test_reset_mid_ls: word=%h busy=%b", bus.word, bus.busy);
    endtask

    initial begin
        bus.en = 0; bus.rx_valid = 0; bus.rx_data = 0; bus.rx_ferror = 0; bus.rx_perror = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_pair();
        test_ms_error();
        test_ls_error();
        test_en_drop();
        test_timeout();
        test_back_to_back_random();
        test_saturate();
        test_reset_mid_ls();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
